// File: rtl/count_ctrl_pkg.sv
// Shared opcodes, readout FSM states and sizing helper for count_ctrl.
package count_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_START    = 3'd1,
        OP_STOP     = 3'd2,
        OP_CLEAR    = 3'd3,
        OP_CAPTURE  = 3'd4,
        OP_LOAD_CMP = 3'd5,
        OP_ARM      = 3'd6,
        OP_ACK      = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    function automatic int nbytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/count_ctrl_core.sv
// count_core: free-running up-counter with a synchronous clear that overrides the enable.
module count_core #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: byte-command front end for the counter with byte-serial snapshot readout.
// Optional compare-match alarm is built only when COUNT_CTRL_CMP_EN is defined.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    output logic             run,
    output logic [WIDTH-1:0] count,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             alarm
);

    localparam int NB = nbytes(WIDTH);
    localparam int IW = $clog2(NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_bad_width
        $error("count_ctrl: WIDTH must be a multiple of 8 and at least 16");
    end

    state_t             state;
    logic [IW-1:0]      idx;
    logic [NB-1:0][7:0] snapshot;
    op_t                op;
    logic               cmd_acc;
    logic               rd_acc;

    // Handshake signals depend only on registered state, never on the valid/ready inputs.
    assign op        = op_t'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign rd_valid  = (state == ST_STREAM);
    assign rd_acc    = rd_valid & rd_ready;
    assign rd_last   = rd_valid & (idx == LAST_IDX);
    assign rd_data   = rd_valid ? snapshot[idx] : 8'h00;

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rstn (rstn),
        .en   (run),
        .clr  (cmd_acc && (op == OP_CLEAR)),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run <= 1'b0;
        end else if (cmd_acc && (op == OP_START)) begin
            run <= 1'b1;
        end else if (cmd_acc && (op == OP_STOP)) begin
            run <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            idx      <= '0;
            snapshot <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_acc && (op == OP_CAPTURE)) begin
                        snapshot <= count;
                        idx      <= '0;
                        state    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (rd_acc) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef COUNT_CTRL_CMP_EN
    logic [WIDTH-1:0] cmp;
    logic             armed;
    logic             alarm_q;
    logic             match;

    assign match = armed && (count == cmp);
    assign alarm = alarm_q;

    // A match outranks a same-edge ACK; a same-edge ARM re-arms after the one-shot fires.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cmp     <= '0;
            armed   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            if (cmd_acc && (op == OP_LOAD_CMP)) begin
                cmp <= {cmd_data, cmp[WIDTH-1:8]};
            end
            if (match) begin
                alarm_q <= 1'b1;
                armed   <= 1'b0;
            end else if (cmd_acc && (op == OP_ACK)) begin
                alarm_q <= 1'b0;
            end
            if (cmd_acc && (op == OP_ARM)) begin
                armed <= 1'b1;
            end
        end
    end
`else
    logic unused_cmd_data;

    assign unused_cmd_data = ^cmd_data;
    assign alarm           = 1'b0;
`endif

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: a 64-bit instance takes command/readout traffic,
// a 16-bit instance covers wrap-around and the compare alarm.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

`ifdef COUNT_CTRL_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       sel;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rd_ready;

    logic        cmd_ready64, run64, rd_valid64, rd_last64, alarm64;
    logic [63:0] count64;
    logic [7:0]  rd_data64;
    logic        cmd_ready16, run16, rd_valid16, rd_last16, alarm16;
    logic [15:0] count16;
    logic [7:0]  rd_data16;

    logic        cur_cmd_ready, cur_run, cur_rd_valid, cur_rd_last, cur_alarm;
    logic [63:0] cur_count;
    logic [7:0]  cur_rd_data;

    always #5 clk = ~clk;

    count_ctrl #(.WIDTH(64)) dut64 (
        .clk(clk), .rstn(rstn),
        .cmd_valid(sel ? 1'b0 : cmd_valid), .cmd_ready(cmd_ready64),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .run(run64), .count(count64),
        .rd_valid(rd_valid64), .rd_ready(sel ? 1'b0 : rd_ready),
        .rd_data(rd_data64), .rd_last(rd_last64), .alarm(alarm64)
    );

    count_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rstn(rstn),
        .cmd_valid(sel ? cmd_valid : 1'b0), .cmd_ready(cmd_ready16),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .run(run16), .count(count16),
        .rd_valid(rd_valid16), .rd_ready(sel ? rd_ready : 1'b0),
        .rd_data(rd_data16), .rd_last(rd_last16), .alarm(alarm16)
    );

    assign cur_cmd_ready = sel ? cmd_ready16 : cmd_ready64;
    assign cur_run       = sel ? run16 : run64;
    assign cur_rd_valid  = sel ? rd_valid16 : rd_valid64;
    assign cur_rd_last   = sel ? rd_last16 : rd_last64;
    assign cur_rd_data   = sel ? rd_data16 : rd_data64;
    assign cur_alarm     = sel ? alarm16 : alarm64;
    assign cur_count     = sel ? {48'h0, count16} : count64;

    // Reference model state, advanced once per clock from the command rules.
    logic [63:0] m_count, m_cmp;
    logic        m_run, m_armed, m_alarm, m_stream;
    int          m_left;
    logic [8:0]  sb[$];
    int          vectors;
    int          miscompares;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_count  = '0;
        m_cmp    = '0;
        m_run    = 1'b0;
        m_armed  = 1'b0;
        m_alarm  = 1'b0;
        m_stream = 1'b0;
        m_left   = 0;
        sb.delete();
    endtask

    task automatic applyStimulus(input logic rs, input logic v, input logic [2:0] op,
                                 input logic [7:0] d, input logic rr);
        logic        acc;
        logic        match;
        int          nb;
        logic [63:0] mask;
        @(negedge clk);
        rstn      = ~rs;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        rd_ready  = rr;
        @(posedge clk);
        nb   = sel ? 2 : 8;
        mask = sel ? 64'h0000_0000_0000_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        if (rs) begin
            modelReset();
        end else begin
            acc   = v && !m_stream;
            match = CMP_EN && m_armed && (m_count == m_cmp);
            if (m_stream && rr) begin
                m_left--;
                if (m_left == 0) m_stream = 1'b0;
            end
            if (acc && op == OP_CAPTURE) begin
                for (int i = 0; i < nb; i++) sb.push_back({(i == nb - 1), 8'(m_count >> (8 * i))});
                m_stream = 1'b1;
                m_left   = nb;
            end
            if (acc && op == OP_CLEAR) m_count = '0;
            else if (m_run) m_count = (m_count + 64'd1) & mask;
            if (acc && op == OP_START) m_run = 1'b1;
            else if (acc && op == OP_STOP) m_run = 1'b0;
            if (CMP_EN) begin
                if (acc && op == OP_LOAD_CMP) m_cmp = (m_cmp >> 8) | (64'(d) << (8 * nb - 8));
                if (match) begin
                    m_alarm = 1'b1;
                    m_armed = 1'b0;
                end else if (acc && op == OP_ACK) begin
                    m_alarm = 1'b0;
                end
                if (acc && op == OP_ARM) m_armed = 1'b1;
            end
        end
        #1;
        checkOutput("count", cur_count, m_count);
        checkOutput("run", 64'(cur_run), 64'(m_run));
        checkOutput("cmd_ready", 64'(cur_cmd_ready), 64'(!m_stream));
        checkOutput("rd_valid", 64'(cur_rd_valid), 64'(m_stream));
        checkOutput("alarm", 64'(cur_alarm), 64'(m_alarm));
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, OP_NOP, 8'h00, rr);
    endtask

    // Monitor: pops the scoreboard on every readout handshake and checks stall stability.
    logic       stalled;
    logic [7:0] held_data;
    logic       held_last;
    logic [8:0] exp_byte;

    initial begin
        stalled   = 1'b0;
        held_data = 8'h00;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rstn === 1'b1 && cur_rd_valid === 1'b1) begin
                if (stalled) begin
                    checkOutput("hold_data", 64'(cur_rd_data), 64'(held_data));
                    checkOutput("hold_last", 64'(cur_rd_last), 64'(held_last));
                end
                if (rd_ready) begin
                    checkOutput("sb_has_byte", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp_byte = sb.pop_front();
                        checkOutput("rd_data", 64'(cur_rd_data), 64'(exp_byte[7:0]));
                        checkOutput("rd_last", 64'(cur_rd_last), 64'(exp_byte[8]));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = cur_rd_data;
                    held_last = cur_rd_last;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int waited;
        vectors     = 0;
        miscompares = 0;
        sel         = 1'b0;
        rstn        = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_data    = 8'h00;
        rd_ready    = 1'b0;
        modelReset();

        applyStimulus(1'b1, 1'b0, OP_NOP, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, OP_NOP, 8'h00, 1'b0);
        checkOutput("reset_rd_data", 64'(cur_rd_data), 64'h0);
        checkOutput("reset_rd_last", 64'(cur_rd_last), 64'h0);

        // Run for exactly ten increments, then the value must freeze.
        applyStimulus(1'b0, 1'b1, OP_START, 8'h00, 1'b0);
        idle(9, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_STOP, 8'h00, 1'b0);
        checkOutput("stop_count", cur_count, 64'd10);
        idle(20, 1'b0);
        checkOutput("stop_hold", cur_count, 64'd10);

        // Full-rate capture with a CLEAR pending behind it.
        applyStimulus(1'b0, 1'b1, OP_START, 8'h00, 1'b0);
        idle(5, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_CAPTURE, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, OP_CLEAR, 8'h00, 1'b1);

        // Stalled capture with rd_ready pattern 1,0,0,1.
        idle(7, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_CAPTURE, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b0, 1'b1, OP_CLEAR, 8'h00, (i % 4 == 0) || (i % 4 == 3));

        // Reset while byte 3 is on the port, then capture again from byte 0.
        idle(6, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_CAPTURE, 8'h00, 1'b1);
        idle(3, 1'b1);
        applyStimulus(1'b1, 1'b0, OP_NOP, 8'h00, 1'b1);
        checkOutput("rst_rd_valid", 64'(cur_rd_valid), 64'h0);
        checkOutput("rst_cmd_ready", 64'(cur_cmd_ready), 64'h1);
        checkOutput("rst_rd_data", 64'(cur_rd_data), 64'h0);
        checkOutput("rst_rd_last", 64'(cur_rd_last), 64'h0);
        checkOutput("rst_count", cur_count, 64'h0);
        checkOutput("rst_run", 64'(cur_run), 64'h0);
        applyStimulus(1'b0, 1'b1, OP_START, 8'h00, 1'b0);
        idle(300, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_CAPTURE, 8'h00, 1'b1);
        idle(10, 1'b1);

        for (int i = 0; i < 1500; i++)
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          8'($urandom), $urandom_range(0, 3) != 0);

        for (int i = 0; i < 20 && cur_rd_valid; i++) applyStimulus(1'b0, 1'b0, OP_NOP, 8'h00, 1'b1);
        checkOutput("drain_idle", 64'(cur_rd_valid), 64'h0);

        // 16-bit instance: compare alarm and wrap-around.
        sel = 1'b1;
        applyStimulus(1'b1, 1'b0, OP_NOP, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, OP_NOP, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_LOAD_CMP, 8'h20, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_LOAD_CMP, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_ARM, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_START, 8'h00, 1'b0);
        waited = 0;
        while (cur_alarm !== 1'b1 && waited < 100) begin
            applyStimulus(1'b0, 1'b0, OP_NOP, 8'h00, 1'b0);
            waited++;
        end
`ifdef COUNT_CTRL_CMP_EN
        checkOutput("alarm_rise_count", cur_count, 64'h21);
`else
        checkOutput("alarm_tied_low", 64'(cur_alarm), 64'h0);
`endif
        idle(3, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_ACK, 8'h00, 1'b0);
        checkOutput("ack_clears", 64'(cur_alarm), 64'h0);
        applyStimulus(1'b0, 1'b1, OP_CAPTURE, 8'h00, 1'b1);
        idle(3, 1'b1);

        waited = 0;
        while (cur_count !== 64'hFFFF && waited < 70000) begin
            applyStimulus(1'b0, 1'b0, OP_NOP, 8'h00, 1'b0);
            waited++;
        end
        applyStimulus(1'b0, 1'b0, OP_NOP, 8'h00, 1'b0);
        checkOutput("wrap_zero", cur_count, 64'h0);
        checkOutput("wrap_run", 64'(cur_run), 64'h1);
        idle(50, 1'b0);
        checkOutput("no_retrigger", 64'(cur_alarm), 64'h0);

        checkOutput("sb_empty", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
